// File: rtl/apb_bus1_initiator_pkg.sv
// Bus[1] shared types (device map, APB vectors) and the initiator's FSM/decode package.
// bus1_types_pkg comes first so the initiator package can import it.
package bus1_types_pkg;
  localparam int CFG_BUS1_PSLV_TOTAL = 7;

  typedef struct packed {
    logic [63:0] addr_start;
    logic [63:0] addr_end;
  } bus1_map_entry_t;

  // 0 uart1, 1 PRCI, 2 DMI, 3 SPI, 4 GPIO, 5 DDR mgmt, 6 PnP; end is exclusive
  localparam bus1_map_entry_t CFG_BUS1_MAP [CFG_BUS1_PSLV_TOTAL] = '{
    '{64'h0000_0000_1001_0000, 64'h0000_0000_1001_1000},
    '{64'h0000_0000_1001_2000, 64'h0000_0000_1001_3000},
    '{64'h0000_0000_1001_E000, 64'h0000_0000_1001_F000},
    '{64'h0000_0000_1005_0000, 64'h0000_0000_1005_1000},
    '{64'h0000_0000_1006_0000, 64'h0000_0000_1006_1000},
    '{64'h0000_0000_100C_0000, 64'h0000_0000_100C_1000},
    '{64'h0000_0000_100F_F000, 64'h0000_0000_1010_0000}
  };

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

  typedef apb_in_type  [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_in_vector;
  typedef apb_out_type [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_out_vector;
endpackage

package apb_bus1_initiator_pkg;
  import bus1_types_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
  localparam int          IDX_W         = $clog2(CFG_BUS1_PSLV_TOTAL + 1);
  localparam logic [IDX_W-1:0] IDX_MISS = IDX_W'(CFG_BUS1_PSLV_TOTAL);

  // Slave index whose window holds addr, or CFG_BUS1_PSLV_TOTAL when nothing matches.
  function automatic logic [IDX_W-1:0] bus1_decode(input logic [63:0] addr);
    logic [IDX_W-1:0] idx;
    idx = IDX_MISS;
    for (int i = CFG_BUS1_PSLV_TOTAL - 1; i >= 0; i--) begin
      if (addr >= CFG_BUS1_MAP[i].addr_start && addr < CFG_BUS1_MAP[i].addr_end) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/apb_bus1_initiator.sv
// Bus[1] APB initiator: decodes one request, runs SETUP/ACCESS on the hit slave, returns data/err.
// Optional ACCESS watchdog enabled by defining APB_BUS1_TIMEOUT_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid holds its payload stable until then, and ready may depend on state only.
module apb_bus1_initiator
  import bus1_types_pkg::*;
  import apb_bus1_initiator_pkg::*;
#(
  parameter int abits          = 48,
  parameter int timeout_cycles = 1024
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [abits-1:0]   i_req_addr,
  input  logic               i_req_write,
  input  logic [31:0]        i_req_wdata,
  input  logic [3:0]         i_req_wstrb,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [31:0]        o_resp_rdata,
  output logic               o_resp_err,
  output bus1_apb_in_vector  o_apbi,
  input  bus1_apb_out_vector i_apbo,
  output state_e             o_dbg_state
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, dec_idx;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  logic             write_q, err_q;
  logic             sel_pready, sel_pslverr;
  logic [31:0]      sel_prdata;
  logic             timeout_hit;

  assign dec_idx = bus1_decode(64'(i_req_addr));

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < CFG_BUS1_PSLV_TOTAL; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_pready  = i_apbo[i].pready;
        sel_pslverr = i_apbo[i].pslverr;
        sel_prdata  = i_apbo[i].prdata;
      end
    end
  end

`ifdef APB_BUS1_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout_cycles + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = (state_q == ST_ACCESS) && !sel_pready &&
                       (cnt_q == CNT_W'(timeout_cycles - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACCESS && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(timeout_cycles);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_req_valid) state_d = (dec_idx == IDX_MISS) ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (sel_pready || timeout_hit) state_d = ST_RESP;
      ST_RESP:   if (i_resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_MISS;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && i_req_valid) begin
        idx_q   <= dec_idx;
        addr_q  <= i_req_addr[31:0];
        write_q <= i_req_write;
        wdata_q <= i_req_wdata;
        wstrb_q <= i_req_wstrb;
        rdata_q <= '0;
        err_q   <= (dec_idx == IDX_MISS);
      end else if (state_q == ST_ACCESS && sel_pready) begin
        rdata_q <= write_q ? 32'h0 : sel_prdata;
        err_q   <= sel_pslverr;
      end else if (timeout_hit) begin
        rdata_q <= TIMEOUT_RDATA;
        err_q   <= 1'b1;
      end
    end
  end

  // Only the latched slave sees the request; every other entry stays all-zero.
  always_comb begin
    o_apbi = '0;
    for (int i = 0; i < CFG_BUS1_PSLV_TOTAL; i++) begin
      if ((state_q == ST_SETUP || state_q == ST_ACCESS) && idx_q == IDX_W'(i)) begin
        o_apbi[i].psel    = 1'b1;
        o_apbi[i].penable = (state_q == ST_ACCESS);
        o_apbi[i].paddr   = addr_q;
        o_apbi[i].pwrite  = write_q;
        o_apbi[i].pwdata  = wdata_q;
        o_apbi[i].pstrb   = wstrb_q;
      end
    end
  end

  assign o_req_ready  = (state_q == ST_IDLE) && i_nrst;
  assign o_resp_valid = (state_q == ST_RESP);
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_apb_bus1_initiator.sv
// Directed bench for apb_bus1_initiator: reads, waited writes, decode misses/boundaries,
// slave error with response backpressure, async reset mid-ACCESS and long ACCESS waits.
module tb_apb_bus1_initiator;
  import bus1_types_pkg::*;
  import apb_bus1_initiator_pkg::*;

  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               nrst;
  logic               req_valid, req_ready, req_write;
  logic [47:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wstrb;
  logic               resp_valid, resp_ready, resp_err;
  logic [31:0]        resp_rdata;
  bus1_apb_in_vector  apbi;
  bus1_apb_out_vector apbo;
  state_e             dbg_state;

  int checks   = 0;
  int failures = 0;

  apb_bus1_initiator #(.abits(48), .timeout_cycles(TO)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_write(req_write), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_apbi(apbi), .i_apbo(apbo), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] psel_vec();
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = apbi[i].psel;
    return v;
  endfunction

  function automatic logic [6:0] penable_vec();
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = apbi[i].penable;
    return v;
  endfunction

  // Unselected slaves answer with noise and an error so any leakage shows up.
  task automatic slaves_default();
    for (int i = 0; i < 7; i++) begin
      apbo[i].pready  = 1'b1;
      apbo[i].pslverr = 1'b1;
      apbo[i].prdata  = 32'hEEEE_0000 | 32'(i);
    end
  endtask

  task automatic send_req(input logic [47:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_wstrb = s;
    tick();
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    slaves_default();
    repeat (2) tick();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++; $display("FAIL reset_resp got v=%b d=%h e=%b exp 0/0/0", resp_valid, resp_rdata, resp_err); end
    checks++; if (apbi !== '0) begin failures++; $display("FAIL reset_apbi got=%h exp=0", apbi); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    nrst = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_read_prci();
    slaves_default();
    apbo[1] = '{pready: 1'b1, prdata: 32'hA5A5_0001, pslverr: 1'b0};
    send_req(48'h0000_1001_2004, 1'b0, 32'h0, 4'h0);
    checks++; if (psel_vec() !== 7'b0000010 || penable_vec() !== 7'b0 || apbi[1].paddr !== 32'h1001_2004 || apbi[1].pwrite !== 1'b0) begin
      failures++; $display("FAIL prci_setup got psel=%b pen=%b paddr=%h pw=%b exp 0000010/0/10012004/0",
                           psel_vec(), penable_vec(), apbi[1].paddr, apbi[1].pwrite); end
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL prci_setup_hs got rdy=%b rv=%b exp 0/0", req_ready, resp_valid); end
    tick();
    checks++; if (psel_vec() !== 7'b0000010 || penable_vec() !== 7'b0000010 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL prci_access got psel=%b pen=%b rv=%b exp 0000010/0000010/0", psel_vec(), penable_vec(), resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0001 || resp_err !== 1'b0 || psel_vec() !== 7'b0) begin
      failures++; $display("FAIL prci_resp got v=%b d=%h e=%b psel=%b exp 1/a5a50001/0/0", resp_valid, resp_rdata, resp_err, psel_vec()); end
    ack_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL prci_done got rv=%b rdy=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_write_gpio_wait();
    slaves_default();
    apbo[4] = '{pready: 1'b0, prdata: 32'hDEAD_BEEF, pslverr: 1'b0};
    send_req(48'h0000_1006_0010, 1'b1, 32'h1234_5678, 4'h3);
    checks++; if (psel_vec() !== 7'b0010000 || apbi[4].pwrite !== 1'b1 || apbi[4].paddr !== 32'h1006_0010) begin
      failures++; $display("FAIL gpio_setup got psel=%b pw=%b paddr=%h exp 0010000/1/10060010", psel_vec(), apbi[4].pwrite, apbi[4].paddr); end
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) apbo[4].pready = 1'b1;
      checks++;
      if (psel_vec() !== 7'b0010000 || penable_vec() !== 7'b0010000 || apbi[4].paddr !== 32'h1006_0010 ||
          apbi[4].pwdata !== 32'h1234_5678 || apbi[4].pstrb !== 4'h3 || apbi[4].pwrite !== 1'b1 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL gpio_access[%0d] got psel=%b pen=%b paddr=%h wd=%h st=%h rv=%b exp 0010000/0010000/10060010/12345678/3/0",
                 k, psel_vec(), penable_vec(), apbi[4].paddr, apbi[4].pwdata, apbi[4].pstrb, resp_valid);
      end
      tick();
    end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || apbi !== '0) begin
      failures++; $display("FAIL gpio_resp got v=%b e=%b d=%h exp 1/0/0 with apbi idle", resp_valid, resp_err, resp_rdata); end
    ack_resp();
    tick();
    checks++; if (resp_valid !== 1'b0 || psel_vec() !== 7'b0) begin
      failures++; $display("FAIL gpio_single got rv=%b psel=%b exp 0/0", resp_valid, psel_vec()); end
  endtask

  task automatic test_miss();
    slaves_default();
    send_req(48'h0000_1003_0000, 1'b0, 32'h0, 4'h0);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || apbi !== '0) begin
      failures++; $display("FAIL miss_resp got v=%b e=%b d=%h exp 1/1/0 with apbi idle", resp_valid, resp_err, resp_rdata); end
    ack_resp();
  endtask

  task automatic test_slverr_backpressure();
    slaves_default();
    apbo[6] = '{pready: 1'b1, prdata: 32'h0BAD_F00D, pslverr: 1'b1};
    send_req(48'h0000_100F_F000, 1'b0, 32'h0, 4'h0);
    tick();
    tick();
    req_valid = 1'b1; req_addr = 48'h0000_1001_2000;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0BAD_F00D || req_ready !== 1'b0 || apbi !== '0) begin
        failures++; $display("FAIL pnp_hold[%0d] got v=%b e=%b d=%h rdy=%b exp 1/1/0badf00d/0", k, resp_valid, resp_err, resp_rdata, req_ready);
      end
      tick();
    end
    req_valid = 1'b0; req_addr = '0;
    ack_resp();
    checks++; if (resp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL pnp_done got rv=%b st=%0d exp 0/0", resp_valid, dbg_state); end
  endtask

  task automatic test_decode_boundary();
    logic [47:0] addrs [3];
    logic [6:0]  exp_psel [3];
    addrs[0] = 48'h0000_1001_1000; exp_psel[0] = 7'b0000000;
    addrs[1] = 48'h0000_1001_E000; exp_psel[1] = 7'b0000100;
    addrs[2] = 48'h0000_100F_FFFC; exp_psel[2] = 7'b1000000;
    for (int t = 0; t < 3; t++) begin
      slaves_default();
      for (int i = 0; i < 7; i++) apbo[i].pslverr = 1'b0;
      send_req(addrs[t], 1'b0, 32'h0, 4'h0);
      checks++;
      if (psel_vec() !== exp_psel[t] || resp_valid !== (exp_psel[t] == 7'b0) || (exp_psel[t] == 7'b0 && resp_err !== 1'b1)) begin
        failures++; $display("FAIL decode[%h] got psel=%b rv=%b e=%b exp psel=%b", addrs[t], psel_vec(), resp_valid, resp_err, exp_psel[t]);
      end
      if (exp_psel[t] != 7'b0) begin
        tick();
        tick();
      end
      ack_resp();
    end
  endtask

  task automatic test_reset_mid_access();
    slaves_default();
    apbo[3].pready = 1'b0;
    send_req(48'h0000_1005_0004, 1'b0, 32'h0, 4'h0);
    tick();
    checks++; if (penable_vec() !== 7'b0001000) begin
      failures++; $display("FAIL rst_pre got pen=%b exp 0001000", penable_vec()); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (psel_vec() !== 7'b0 || penable_vec() !== 7'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_async got psel=%b pen=%b rv=%b rdy=%b exp 0/0/0/0", psel_vec(), penable_vec(), resp_valid, req_ready); end
    tick();
    nrst = 1'b1;
    apbo[3].pready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL rst_after got rv=%b rdy=%b st=%0d exp 0/1/0", resp_valid, req_ready, dbg_state); end
  endtask

  task automatic test_access_wait();
    slaves_default();
    apbo[3] = '{pready: 1'b0, prdata: 32'h00C0_FFEE, pslverr: 1'b0};
    send_req(48'h0000_1005_0008, 1'b0, 32'h0, 4'h0);
    tick();
`ifdef APB_BUS1_TIMEOUT_EN
    repeat (TO - 1) tick();
    checks++; if (resp_valid !== 1'b0 || penable_vec() !== 7'b0001000) begin
      failures++; $display("FAIL to_last_access got rv=%b pen=%b exp 0/0001000", resp_valid, penable_vec()); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'hFFFF_FFFF || apbi !== '0) begin
      failures++; $display("FAIL to_resp got v=%b e=%b d=%h exp 1/1/ffffffff with apbi idle", resp_valid, resp_err, resp_rdata); end
    apbo[3].pready = 1'b1;
    ack_resp();
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || apbi !== '0) begin
      failures++; $display("FAIL to_late_pready got rv=%b rdy=%b exp 0/1", resp_valid, req_ready); end
`else
    repeat (20) tick();
    checks++; if (resp_valid !== 1'b0 || psel_vec() !== 7'b0001000 || penable_vec() !== 7'b0001000) begin
      failures++; $display("FAIL wait_long got rv=%b psel=%b pen=%b exp 0/0001000/0001000", resp_valid, psel_vec(), penable_vec()); end
    apbo[3].pready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h00C0_FFEE) begin
      failures++; $display("FAIL wait_resp got v=%b e=%b d=%h exp 1/0/00c0ffee", resp_valid, resp_err, resp_rdata); end
    ack_resp();
`endif
  endtask

  initial begin
    test_reset();
    test_read_prci();
    test_write_gpio_wait();
    test_miss();
    test_slverr_backpressure();
    test_decode_boundary();
    test_reset_mid_access();
    test_access_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
